multicycle_control_32: RTL and testbench
========================================

Name: multicycle_control_32

Overview:
Main sequencer for the multi-cycle MIPS datapath. Walks each instruction through fetch, decode, execute, memory and writeback. Drives the datapath enables, the mux selects and the 2-bit alu_op. alu_op feeds the existing ALU-control decoder, which combines it with the instruction's func field. Owns the memory request/ready handshake, traps illegal opcodes and counts retired instructions.

Parameters:
CNT_W, 32, width of the retired-instruction counter.
LW_OP, 6'b100011, load-word opcode.
SW_OP, 6'b101011, store-word opcode.
BEQ_OP, 6'b000100, branch-equal opcode.
J_OP, 6'b000010, jump opcode.
RTYPE_OP, 6'b000000, R-type opcode.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  synchronous, active-low reset.
opcode  in  6  instruction-register bits [31:26].
func  in  6  instruction-register bits [5:0].
mem_ready  in  1  memory completes the current access this cycle.
mem_read  out  1  memory read request.
mem_write  out  1  memory write request.
i_or_d  out  1  address select: 0 = PC, 1 = ALUOut.
ir_write  out  1  instruction-register load.
pc_write  out  1  unconditional PC load.
pc_write_cond  out  1  PC load if ALU zero.
pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = rs register.
alu_op  out  2  00 = add (memory/PC), 01 = sub (beq), 10 = decode func.
alu_src_a  out  1  0 = PC, 1 = A register.
alu_src_b  out  2  00 = B register, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left 2.
reg_write  out  1  register-file write.
reg_dst  out  1  0 = rt, 1 = rd.
mem_to_reg  out  1  0 = ALUOut, 1 = MDR.
err_illegal_opcode  out  1  sticky trap flag.
retire  out  1  one-cycle pulse as an instruction completes.
instr_count  out  CNT_W  retired-instruction count.
state_dbg  out  4  current state encoding.

Behaviour:
- States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC, ALU_WB, BRANCH, JUMP, JR, TRAP.
- Output rule: all outputs are decoded from the state register only, except ir_write/pc_write in FETCH, which are gated by mem_ready.
- Reset, rst_n low at a clock edge, from any state including mid-access:
  - state is set to IDLE;
  - instr_count and err_illegal_opcode are cleared to 0;
  - every output is 0.
- IDLE: all outputs 0. Goes to FETCH on the next cycle.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - Holds while mem_ready=0.
  - When mem_ready=1: ir_write=1 and pc_write=1 for that single cycle, then go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state:
  - LW or SW → MEM_ADDR;
  - RTYPE with func=6'b001000 → JR;
  - any other RTYPE → EXEC;
  - BEQ → BRANCH;
  - J → JUMP;
  - anything else → TRAP.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state: MEM_RD for LW, MEM_WR for SW.
- MEM_RD: mem_read=1, i_or_d=1. Holds until mem_ready, then goes to MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Retires. Next state FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Holds until mem_ready. Retires on the mem_ready cycle, then goes to FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next state ALU_WB.
- ALU_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Retires. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Retires. Next state FETCH.
- JUMP: pc_write=1, pc_source=10. Retires. Next state FETCH.
- JR: pc_write=1, pc_source=11. Retires. Next state FETCH.
- TRAP: all enables 0, err_illegal_opcode=1. Stays in TRAP until reset; no retire.
- Request stability: mem_read/mem_write stay asserted and unchanged throughout a stall.
- Counter:
  - retire=1 for exactly one cycle per instruction;
  - instr_count increments by 1 on each retire cycle and wraps modulo 2^CNT_W;
  - its new value is visible the cycle after retire.
- mem_ready is ignored in every state that does not access memory.
- Latency with mem_ready tied high: R-type 4 cycles; lw 5; sw 4; beq 3; j 3; jr 3.

Decomposition:
- Package mips_ctrl_pkg holds:
  - the state enum;
  - the opcode constants and the jr func code (shared with the ALU-control decoder);
  - the alu_op, alu_src_b and pc_source encodings.
- Sub-module retire_counter: CNT_W-wide, wrapping, synchronous active-low clear.

Test Plan:
1. Reset mid-MEM_RD (rst_n=0 for 1 cycle) → next cycle state_dbg=IDLE, all outputs 0, instr_count=0; FETCH one cycle after rst_n returns high.
2. R-type add (opcode 0, func 6'b100000), mem_ready=1 → sequence FETCH, DECODE, EXEC, ALU_WB; alu_op=10 in EXEC; reg_write=1 with reg_dst=1 in ALU_WB; instr_count goes 0 → 1.
3. lw with mem_ready low for 3 cycles in FETCH and 2 in MEM_RD → mem_read held throughout; ir_write pulses once; total 10 cycles; reg_write=1 with mem_to_reg=1.
4. beq then j then jr (func 6'b001000) → pc_write_cond=1/pc_source=01; then pc_write=1/pc_source=10; then pc_write=1/pc_source=11; three retire pulses; instr_count=3.
5. opcode 6'b111111 → TRAP after DECODE; err_illegal_opcode=1 and held; no further mem_read; instr_count unchanged; cleared only by reset.
6. CNT_W=4, 17 back-to-back R-type instructions → instr_count wraps 15 → 0 and then reads 1.

Source files
------------

// File: rtl/multicycle_control_32_pkg.sv
// Shared encodings for the multi-cycle MIPS controller and the ALU-control decoder.
// Opcodes, the jr func code, mux selects and the sequencer state enum.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC     = 4'd7,
        S_ALU_WB   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_JR       = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] FUNC_JR  = 6'b001000;

    localparam logic [1:0] ALU_OP_ADD  = 2'b00;
    localparam logic [1:0] ALU_OP_SUB  = 2'b01;
    localparam logic [1:0] ALU_OP_FUNC = 2'b10;

    localparam logic [1:0] SRC_B_REG     = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_RS     = 2'b11;

endpackage

// File: rtl/multicycle_control_32_if.sv
// Controller <-> datapath/memory bundle. master = sequencer, slave = datapath side.
interface multicycle_control_32_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       func;
    logic             mem_ready;
    logic             mem_read;
    logic             mem_write;
    logic             i_or_d;
    logic             ir_write;
    logic             pc_write;
    logic             pc_write_cond;
    logic [1:0]       pc_source;
    logic [1:0]       alu_op;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic             reg_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             err_illegal_opcode;
    logic             retire;
    logic [CNT_W-1:0] instr_count;
    logic [3:0]       state_dbg;

    modport master (
        input  opcode, func, mem_ready,
        output mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
               pc_source, alu_op, alu_src_a, alu_src_b, reg_write, reg_dst,
               mem_to_reg, err_illegal_opcode, retire, instr_count, state_dbg
    );

    modport slave (
        output opcode, func, mem_ready,
        input  mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
               pc_source, alu_op, alu_src_a, alu_src_b, reg_write, reg_dst,
               mem_to_reg, err_illegal_opcode, retire, instr_count, state_dbg
    );
endinterface

// File: rtl/multicycle_control_32_retire_counter.sv
// Retired-instruction counter: wraps modulo 2^CNT_W, synchronous active-low clear.
module retire_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_control_32.sv
// Multi-cycle MIPS main sequencer: fetch/decode/execute/memory/writeback control,
// memory handshake, illegal-opcode trap and retire counting.
//
// state    | meaning
// IDLE     | post-reset, all outputs low
// FETCH    | read instruction at PC, PC+4 on mem_ready
// DECODE   | register read, branch target into ALUOut
// MEM_ADDR | effective address for lw/sw
// MEM_RD   | data read, waits for mem_ready
// MEM_WB   | load data into rt
// MEM_WR   | data write, retires on mem_ready
// EXEC     | R-type ALU operation
// ALU_WB   | ALU result into rd
// BRANCH   | beq compare, conditional PC load
// JUMP     | PC <= jump target
// JR       | PC <= rs
// TRAP     | illegal opcode, parked until reset
module multicycle_control_32
    import mips_ctrl_pkg::*;
#(
    parameter int         CNT_W    = 32,
    parameter logic [5:0] LW_OP    = OP_LW,
    parameter logic [5:0] SW_OP    = OP_SW,
    parameter logic [5:0] BEQ_OP   = OP_BEQ,
    parameter logic [5:0] J_OP     = OP_J,
    parameter logic [5:0] RTYPE_OP = OP_RTYPE
) (
    input logic                    clk,
    input logic                    rst_n,
    multicycle_control_32_if.master bus
);

    state_t           state;
    state_t           state_next;
    logic             retire;
    logic [CNT_W-1:0] instr_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     state_next = S_FETCH;
            S_FETCH:    if (bus.mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                if (bus.opcode == LW_OP || bus.opcode == SW_OP) begin
                    state_next = S_MEM_ADDR;
                end else if (bus.opcode == RTYPE_OP) begin
                    state_next = (bus.func == FUNC_JR) ? S_JR : S_EXEC;
                end else if (bus.opcode == BEQ_OP) begin
                    state_next = S_BRANCH;
                end else if (bus.opcode == J_OP) begin
                    state_next = S_JUMP;
                end else begin
                    state_next = S_TRAP;
                end
            end
            S_MEM_ADDR: state_next = (bus.opcode == SW_OP) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (bus.mem_ready) state_next = S_MEM_WB;
            S_MEM_WR:   if (bus.mem_ready) state_next = S_FETCH;
            S_EXEC:     state_next = S_ALU_WB;
            S_MEM_WB,
            S_ALU_WB,
            S_BRANCH,
            S_JUMP,
            S_JR:       state_next = S_FETCH;
            S_TRAP:     state_next = S_TRAP;
            default:    state_next = S_IDLE;
        endcase
    end

    // Outputs come from the state register; only FETCH loads and the store retire see mem_ready.
    always_comb begin
        bus.mem_read           = 1'b0;
        bus.mem_write          = 1'b0;
        bus.i_or_d             = 1'b0;
        bus.ir_write           = 1'b0;
        bus.pc_write           = 1'b0;
        bus.pc_write_cond      = 1'b0;
        bus.pc_source          = PC_SRC_ALU;
        bus.alu_op             = ALU_OP_ADD;
        bus.alu_src_a          = 1'b0;
        bus.alu_src_b          = SRC_B_REG;
        bus.reg_write          = 1'b0;
        bus.reg_dst            = 1'b0;
        bus.mem_to_reg         = 1'b0;
        bus.err_illegal_opcode = 1'b0;
        retire                 = 1'b0;
        case (state)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = SRC_B_FOUR;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            S_DECODE:   bus.alu_src_b = SRC_B_IMM_SH2;
            S_MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRC_B_IMM;
            end
            S_MEM_RD: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                retire         = 1'b1;
            end
            S_MEM_WR: begin
                bus.mem_write = 1'b1;
                bus.i_or_d    = 1'b1;
                retire        = bus.mem_ready;
            end
            S_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALU_OP_FUNC;
            end
            S_ALU_WB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
                retire        = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = ALU_OP_SUB;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = PC_SRC_ALUOUT;
                retire            = 1'b1;
            end
            S_JUMP: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = PC_SRC_JUMP;
                retire        = 1'b1;
            end
            S_JR: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = PC_SRC_RS;
                retire        = 1'b1;
            end
            S_TRAP:  bus.err_illegal_opcode = 1'b1;
            default: ;
        endcase
    end

    retire_counter #(
        .CNT_W (CNT_W)
    ) u_retire_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (retire),
        .count (instr_count)
    );

    assign bus.retire      = retire;
    assign bus.instr_count = instr_count;
    assign bus.state_dbg   = state;

endmodule

// File: tb/tb_multicycle_control_32.sv
// Bench for multicycle_control_32: directed scenarios plus a randomized instruction
// mix checked against an instruction-level latency/signature model.
module tb_multicycle_control_32;
    import mips_ctrl_pkg::*;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic [5:0] opcode    = 6'd0;
    logic [5:0] func      = 6'd0;
    logic       mem_ready = 1'b0;

    int checks  = 0;
    int errors  = 0;
    int retired = 0;

    logic [3:0] seq_state[$];
    logic [1:0] seq_alu[$];

    always #5 clk = ~clk;

    multicycle_control_32_if #(.CNT_W(32)) bus32 ();
    multicycle_control_32_if #(.CNT_W(4))  bus4 ();

    assign bus32.opcode    = opcode;
    assign bus32.func      = func;
    assign bus32.mem_ready = mem_ready;
    assign bus4.opcode     = opcode;
    assign bus4.func       = func;
    assign bus4.mem_ready  = mem_ready;

    multicycle_control_32 #(.CNT_W(32)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus32));
    multicycle_control_32 #(.CNT_W(4))  dut_4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    function automatic logic [17:0] all_outs();
        return {bus32.mem_read, bus32.mem_write, bus32.i_or_d, bus32.ir_write,
                bus32.pc_write, bus32.pc_write_cond, bus32.pc_source, bus32.alu_op,
                bus32.alu_src_a, bus32.alu_src_b, bus32.reg_write, bus32.reg_dst,
                bus32.mem_to_reg, bus32.err_illegal_opcode, bus32.retire};
    endfunction

    // Instruction-level model: cycles with no stalls, and the writeback/PC signature
    // {reg_write, reg_dst, mem_to_reg, mem_write, pc_write, pc_write_cond, pc_source, alu_op}
    // seen on the retire cycle.
    function automatic int base_lat(logic [5:0] op, logic [5:0] fn);
        case (op)
            6'b000000: return (fn == 6'b001000) ? 3 : 4;
            6'b100011: return 5;
            6'b101011: return 4;
            6'b000100: return 3;
            6'b000010: return 3;
            default:   return 0;
        endcase
    endfunction

    function automatic logic [9:0] ret_sig(logic [5:0] op, logic [5:0] fn);
        case (op)
            6'b000000: return (fn == 6'b001000) ? 10'b0000_1_0_11_00 : 10'b1100_0_0_00_00;
            6'b100011: return 10'b1010_0_0_00_00;
            6'b101011: return 10'b0001_0_0_00_00;
            6'b000100: return 10'b0000_0_1_01_01;
            6'b000010: return 10'b0000_1_0_10_00;
            default:   return 10'b0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        retired = 0;
    endtask

    // Runs one instruction starting in FETCH; fst/mst are wait cycles on the fetch and data access.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fst, input int mst);
        int fl = fst;
        int ml = mst;
        int cyc = 0;
        int irw = 0;
        int fetch_rd = 0;
        int data_acc = 0;
        bit done = 0;
        bit is_mem;
        logic [9:0] sig = '0;
        int exp_lat;
        is_mem = (op == 6'b100011) || (op == 6'b101011);
        exp_lat = base_lat(op, fn) + fst + (is_mem ? mst : 0);
        opcode = op;
        func   = fn;
        seq_state.delete();
        seq_alu.delete();
        while (!done && cyc < 64) begin
            if (bus32.mem_read || bus32.mem_write) begin
                if (!bus32.i_or_d) begin
                    mem_ready = (fl == 0);
                    if (fl > 0) fl--;
                end else begin
                    mem_ready = (ml == 0);
                    if (ml > 0) ml--;
                end
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            seq_state.push_back(bus32.state_dbg);
            seq_alu.push_back(bus32.alu_op);
            if (bus32.ir_write) irw++;
            if (bus32.mem_read && !bus32.i_or_d) fetch_rd++;
            if ((bus32.mem_read || bus32.mem_write) && bus32.i_or_d) data_acc++;
            cyc++;
            if (bus32.retire) begin
                done = 1;
                sig = {bus32.reg_write, bus32.reg_dst, bus32.mem_to_reg, bus32.mem_write,
                       bus32.pc_write, bus32.pc_write_cond, bus32.pc_source, bus32.alu_op};
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL retire_timeout op=%b func=%b: no retire within %0d cycles", op, fn, cyc);
            do_reset();
            return;
        end
        retired++;
        checks++;
        if (cyc !== exp_lat) begin
            errors++;
            $display("FAIL latency op=%b: got %0d cycles, expected %0d", op, cyc, exp_lat);
        end
        checks++;
        if (irw !== 1) begin
            errors++;
            $display("FAIL ir_write_pulses op=%b: got %0d, expected 1", op, irw);
        end
        checks++;
        if (fetch_rd !== fst + 1) begin
            errors++;
            $display("FAIL fetch_read_hold op=%b: got %0d cycles, expected %0d", op, fetch_rd, fst + 1);
        end
        checks++;
        if (data_acc !== (is_mem ? mst + 1 : 0)) begin
            errors++;
            $display("FAIL data_access_hold op=%b: got %0d cycles, expected %0d", op, data_acc,
                     is_mem ? mst + 1 : 0);
        end
        checks++;
        if (sig !== ret_sig(op, fn)) begin
            errors++;
            $display("FAIL retire_signature op=%b func=%b: got %b, expected %b", op, fn, sig, ret_sig(op, fn));
        end
        checks++;
        if (bus32.retire !== 1'b0) begin
            errors++;
            $display("FAIL retire_width op=%b: retire still %b after retire cycle", op, bus32.retire);
        end
        checks++;
        if (bus32.instr_count !== 32'(retired)) begin
            errors++;
            $display("FAIL instr_count: got %0d, expected %0d", bus32.instr_count, retired);
        end
        checks++;
        if (bus4.instr_count !== 4'(retired % 16)) begin
            errors++;
            $display("FAIL instr_count_w4: got %0d, expected %0d", bus4.instr_count, retired % 16);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mem_ready = 1'b1;
        tick();
        checks++;
        if (bus32.state_dbg !== 4'(S_IDLE) || all_outs() !== 18'd0 || bus32.instr_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: state=%0d outs=%b count=%0d, expected IDLE/0/0",
                     bus32.state_dbg, all_outs(), bus32.instr_count);
        end
        rst_n = 1'b1;
        tick();
        retired = 0;
        checks++;
        if (bus32.state_dbg !== 4'(S_FETCH)) begin
            errors++;
            $display("FAIL reset_exit: state=%0d, expected FETCH", bus32.state_dbg);
        end
    endtask

    task automatic test_rtype();
        logic [15:0] got;
        run_instr(6'b000000, 6'b100000, 0, 0);
        got = (seq_state.size() >= 4) ? {seq_state[0], seq_state[1], seq_state[2], seq_state[3]} : 16'hxxxx;
        checks++;
        if (got !== {4'(S_FETCH), 4'(S_DECODE), 4'(S_EXEC), 4'(S_ALU_WB)}) begin
            errors++;
            $display("FAIL rtype_sequence: got %h, expected FETCH,DECODE,EXEC,ALU_WB", got);
        end
        checks++;
        if (seq_alu.size() < 3 || seq_alu[2] !== 2'b10) begin
            errors++;
            $display("FAIL rtype_alu_op: exec alu_op not 10 (sequence length %0d)", seq_alu.size());
        end
    endtask

    task automatic test_lw_stall();
        run_instr(6'b100011, 6'($urandom), 3, 2);
    endtask

    task automatic test_branch_jump();
        do_reset();
        run_instr(6'b000100, 6'($urandom), 0, 0);
        run_instr(6'b000010, 6'($urandom), 0, 0);
        run_instr(6'b000000, 6'b001000, 0, 0);
        checks++;
        if (bus32.instr_count !== 32'd3) begin
            errors++;
            $display("FAIL branch_jump_count: got %0d, expected 3", bus32.instr_count);
        end
    endtask

    task automatic test_random();
        logic [5:0] ops[6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b000000};
        for (int i = 0; i < 40; i++) begin
            int k = $urandom_range(0, 5);
            logic [5:0] fn = 6'($urandom);
            if (k == 5) fn = 6'b001000;
            else if (k == 0 && fn == 6'b001000) fn = 6'b100010;
            run_instr(ops[k], fn, $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    task automatic test_reset_mid_access();
        opcode = 6'b100011;
        mem_ready = 1'b1;
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        checks++;
        if (bus32.state_dbg !== 4'(S_MEM_RD) || bus32.mem_read !== 1'b1) begin
            errors++;
            $display("FAIL reach_mem_rd: state=%0d mem_read=%b, expected MEM_RD/1",
                     bus32.state_dbg, bus32.mem_read);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (bus32.state_dbg !== 4'(S_IDLE) || all_outs() !== 18'd0 || bus32.instr_count !== 32'd0
            || bus4.instr_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid_access: state=%0d outs=%b count=%0d, expected IDLE/0/0",
                     bus32.state_dbg, all_outs(), bus32.instr_count);
        end
        rst_n = 1'b1;
        tick();
        retired = 0;
        checks++;
        if (bus32.state_dbg !== 4'(S_FETCH)) begin
            errors++;
            $display("FAIL reset_mid_exit: state=%0d, expected FETCH", bus32.state_dbg);
        end
    endtask

    task automatic test_back_to_back_wrap();
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            run_instr(6'b000000, 6'b100000, 0, 0);
            if (i == 15 || i == 16) begin
                checks++;
                if (bus4.instr_count !== ((i == 15) ? 4'd15 : 4'd0)) begin
                    errors++;
                    $display("FAIL wrap_point_%0d: got %0d, expected %0d", i, bus4.instr_count,
                             (i == 15) ? 15 : 0);
                end
            end
        end
        checks++;
        if (bus4.instr_count !== 4'd1 || bus32.instr_count !== 32'd17) begin
            errors++;
            $display("FAIL wrap_final: w4=%0d w32=%0d, expected 1 and 17",
                     bus4.instr_count, bus32.instr_count);
        end
    endtask

    task automatic test_trap();
        logic [31:0] cnt_before = bus32.instr_count;
        opcode = 6'b111111;
        mem_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (bus32.state_dbg !== 4'(S_TRAP) || bus32.err_illegal_opcode !== 1'b1) begin
            errors++;
            $display("FAIL trap_entry: state=%0d err=%b, expected TRAP/1",
                     bus32.state_dbg, bus32.err_illegal_opcode);
        end
        for (int i = 0; i < 10; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (bus32.err_illegal_opcode !== 1'b1 || bus32.mem_read !== 1'b0 || bus32.mem_write !== 1'b0
                || bus32.retire !== 1'b0 || bus32.instr_count !== cnt_before) begin
                errors++;
                $display("FAIL trap_hold cycle %0d: err=%b rd=%b wr=%b retire=%b count=%0d, expected 1/0/0/0/%0d",
                         i, bus32.err_illegal_opcode, bus32.mem_read, bus32.mem_write,
                         bus32.retire, bus32.instr_count, cnt_before);
            end
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (bus32.err_illegal_opcode !== 1'b0 || bus32.instr_count !== 32'd0) begin
            errors++;
            $display("FAIL trap_clear: err=%b count=%0d, expected 0/0",
                     bus32.err_illegal_opcode, bus32.instr_count);
        end
        rst_n = 1'b1;
        tick();
        retired = 0;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_stall();
        test_branch_jump();
        test_random();
        test_reset_mid_access();
        test_back_to_back_wrap();
        test_trap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
